// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon table, block/word types and the
// key-schedule state encoding. Used by aes_key_schedule and later by the
// cipher round stages.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } aes_state_e;

    // Round constants indexed directly by round number (1..10). The table is
    // padded to 16 entries so any 4-bit index stays in range; entries 0 and
    // 11..15 are never used by the schedule.
    localparam logic [7:0] AES_RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: one byte in, one byte out, purely combinational.
// Instantiated four times for SubWord in the key schedule and reused by the
// SubBytes stage.
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub_val = SBOX[byte_val];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion. Emits round keys 0..NR one at a time on a
// valid/ready handshake; each key is derived from the previous one in a single
// combinational step (4 S-box lookups + XOR chain) and registered.
// Optional feature macro: AES_KEY_SCHED_CACHE_EN -- keeps the last completed
// schedule in an 11-entry cache so a start with reuse=1 replays it.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         reuse,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    aes_state_e state_r;
    aes_state_e state_nxt_s;

    aes_block_t key_r;
    logic [3:0] idx_r;
    logic       valid_r;
    logic       done_r;

    logic       accept_s;
    logic       adv_s;
    logic       last_hs_s;
    logic       hs_s;

    aes_block_t calc_key_s;
    aes_block_t load_key_s;
    aes_block_t next_key_s;

    aes_word_t  w0_s, w1_s, w2_s, w3_s;
    aes_word_t  rot_s, sub_s;
    aes_word_t  nw0_s, nw1_s, nw2_s, nw3_s;

    // ------------------------------------------------------------------
    // Next round key from the current one
    // ------------------------------------------------------------------
    assign w0_s  = key_r[127:96];
    assign w1_s  = key_r[95:64];
    assign w2_s  = key_r[63:32];
    assign w3_s  = key_r[31:0];
    assign rot_s = {w3_s[23:0], w3_s[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            aes_sbox u_sbox (
                .byte_val (rot_s[8*g +: 8]),
                .sub_val  (sub_s[8*g +: 8])
            );
        end
    endgenerate

    assign nw0_s      = w0_s ^ sub_s ^ {AES_RCON[idx_r + 4'd1], 24'h000000};
    assign nw1_s      = w1_s ^ nw0_s;
    assign nw2_s      = w2_s ^ nw1_s;
    assign nw3_s      = w3_s ^ nw2_s;
    assign calc_key_s = {nw0_s, nw1_s, nw2_s, nw3_s};

    // ------------------------------------------------------------------
    // Control: accepted start, advancing handshake, final handshake
    // ------------------------------------------------------------------
    // Next-state and handshake decode; in RUN rk_valid is always high, so a
    // handshake is simply rk_ready.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        adv_s       = 1'b0;
        last_hs_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (idx_r == LAST_IDX) begin
                        last_hs_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        adv_s       = 1'b1;
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign hs_s = adv_s | last_hs_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Optional replay cache
    // ------------------------------------------------------------------
`ifdef AES_KEY_SCHED_CACHE_EN
    aes_block_t cache_r [0:AES_NR];
    logic       cache_ok_r;
    logic       replay_r;
    logic       use_cache_s;

    assign use_cache_s = reuse & cache_ok_r;

    // Record every handed-over key at its round index.
    always_ff @(posedge clk) begin
        if (hs_s) begin
            cache_r[idx_r] <= key_r;
        end
    end

    // Cache validity and replay-mode flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_ok_r <= 1'b0;
            replay_r   <= 1'b0;
        end else begin
            if (last_hs_s) begin
                cache_ok_r <= 1'b1;
            end else if (accept_s && !use_cache_s) begin
                cache_ok_r <= 1'b0;
            end
            if (accept_s) begin
                replay_r <= use_cache_s;
            end
        end
    end

    // Key source selection: cached schedule when replaying, else computed.
    always_comb begin
        load_key_s = key_in;
        next_key_s = calc_key_s;
        if (use_cache_s) begin
            load_key_s = cache_r[0];
        end else begin
            load_key_s = key_in;
        end
        if (replay_r) begin
            next_key_s = cache_r[idx_r + 4'd1];
        end else begin
            next_key_s = calc_key_s;
        end
    end
`else
    logic unused_reuse_s;

    assign unused_reuse_s = reuse;
    assign load_key_s     = key_in;
    assign next_key_s     = calc_key_s;
`endif

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    // Key/index registers plus registered valid and done flags. The key
    // register keeps the round-10 key after the schedule finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r   <= 128'h0;
            idx_r   <= 4'd0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                key_r <= load_key_s;
                idx_r <= 4'd0;
            end else if (adv_s) begin
                key_r <= next_key_s;
                idx_r <= idx_r + 4'd1;
            end
            valid_r <= (state_nxt_s == RUN);
            done_r  <= last_hs_s;
        end
    end

    assign rk       = key_r;
    assign rk_idx   = idx_r;
    assign rk_valid = valid_r;
    assign busy     = valid_r;
    assign done     = done_r;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed self-checking bench for aes_key_schedule. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_aes_key_schedule;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] ZERO_RK [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NEW_KEY   = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         reuse;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    aes_key_schedule #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .reuse    (reuse),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle; returns at the falling edge where key 0 is shown.
    task automatic do_start(input logic [127:0] k, input logic r);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        reuse  = r;
        @(negedge clk);
        start  = 1'b0;
        reuse  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rk !== 128'h0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got rk=%h idx=%0d valid=%b busy=%b done=%b, want all zero",
                     rk, rk_idx, rk_valid, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got valid=%b busy=%b done=%b, want 0 0 0", rk_valid, busy, done);
        end
    endtask

    task automatic test_fips_stream();
        rk_ready = 1'b1;
        do_start(FIPS_RK[0], 1'b0);
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_idx !== 4'(i) || rk !== FIPS_RK[i] || done !== 1'b0) begin
                failures++;
                $display("FAIL fips_stream idx%0d: got valid=%b busy=%b idx=%0d rk=%h done=%b, want 1 1 %0d %h 0",
                         i, rk_valid, busy, rk_idx, rk, done, i, FIPS_RK[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk !== FIPS_RK[10]) begin
            failures++;
            $display("FAIL fips_done: got done=%b valid=%b busy=%b rk=%h, want 1 0 0 %h",
                     done, rk_valid, busy, rk, FIPS_RK[10]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL fips_done_pulse: got done=%b one cycle later, want 0", done);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_stall();
        int   exp_i;
        int   stall;
        int   cyc;
        logic hs;
        logic rdy;
        exp_i    = 0;
        stall    = 0;
        cyc      = 0;
        hs       = 1'b0;
        rk_ready = 1'b0;
        do_start(FIPS_RK[0], 1'b0);
        while (exp_i <= 10 && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (hs) exp_i++;
            if (exp_i <= 10) begin
                checks++;
                if (rk_valid !== 1'b1 || rk_idx !== 4'(exp_i) || rk !== FIPS_RK[exp_i] || done !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_seq cyc%0d: got valid=%b idx=%0d rk=%h done=%b, want 1 %0d %h 0",
                             cyc, rk_valid, rk_idx, rk, done, exp_i, FIPS_RK[exp_i]);
                end
                if (exp_i == 4 && stall < 7) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
                rk_ready = rdy;
                hs       = rdy;
            end
        end
        checks++;
        if (exp_i != 11) begin
            failures++;
            $display("FAIL stall_timeout: got index %0d after %0d cycles, want 11", exp_i, cyc);
        end else if (done !== 1'b1 || rk_valid !== 1'b0 || rk !== FIPS_RK[10]) begin
            failures++;
            $display("FAIL stall_done: got done=%b valid=%b rk=%h, want 1 0 %h", done, rk_valid, rk, FIPS_RK[10]);
        end
        rk_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        rk_ready = 1'b1;
        do_start(FIPS_RK[0], 1'b0);
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== FIPS_RK[i]) begin
                failures++;
                $display("FAIL start_ignored idx%0d: got valid=%b idx=%0d rk=%h, want 1 %0d %h",
                         i, rk_valid, rk_idx, rk, i, FIPS_RK[i]);
            end
            if (i == 5) begin
                start  = 1'b1;
                key_in = OTHER_KEY;
            end else begin
                start  = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || rk !== FIPS_RK[10]) begin
            failures++;
            $display("FAIL start_ignored_done: got done=%b rk=%h, want 1 %h", done, rk, FIPS_RK[10]);
        end
        rk_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        rk_ready = 1'b1;
        do_start(FIPS_RK[0], 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if (rk_idx !== 4'd6 || rk !== FIPS_RK[6]) begin
            failures++;
            $display("FAIL rst_mid_pre: got idx=%0d rk=%h, want 6 %h", rk_idx, rk, FIPS_RK[6]);
        end
        rk_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rk !== 128'h0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: got rk=%h idx=%0d valid=%b busy=%b done=%b, want all zero",
                     rk, rk_idx, rk_valid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(NEW_KEY, 1'b0);
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk !== NEW_KEY) begin
            failures++;
            $display("FAIL rst_mid_restart: got valid=%b idx=%0d rk=%h, want 1 0 %h", rk_valid, rk_idx, rk, NEW_KEY);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        rk_ready = 1'b1;
        do_start(ZERO_RK[0], 1'b0);
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== ZERO_RK[i]) begin
                failures++;
                $display("FAIL zero_key idx%0d: got valid=%b idx=%0d rk=%h, want 1 %0d %h",
                         i, rk_valid, rk_idx, rk, i, ZERO_RK[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || rk !== ZERO_RK[10]) begin
            failures++;
            $display("FAIL zero_done: got done=%b rk=%h, want 1 %h", done, rk, ZERO_RK[10]);
        end
        start  = 1'b1;
        key_in = FIPS_RK[0];
        reuse  = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== FIPS_RK[i] || done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_second idx%0d: got valid=%b idx=%0d rk=%h done=%b, want 1 %0d %h 0",
                         i, rk_valid, rk_idx, rk, done, i, FIPS_RK[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: got done=%b, want 1", done);
        end
        rk_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reuse();
        logic [127:0] exp_rk [0:10];
        for (int i = 0; i <= 10; i++) begin
`ifdef AES_KEY_SCHED_CACHE_EN
            exp_rk[i] = FIPS_RK[i];
`else
            exp_rk[i] = ZERO_RK[i];
`endif
        end
        rk_ready = 1'b1;
        do_start(128'h0, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== exp_rk[i]) begin
                failures++;
                $display("FAIL reuse idx%0d: got valid=%b idx=%0d rk=%h, want 1 %0d %h",
                         i, rk_valid, rk_idx, rk, i, exp_rk[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || rk_valid !== 1'b0) begin
            failures++;
            $display("FAIL reuse_done: got done=%b valid=%b, want 1 0", done, rk_valid);
        end
        rk_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = 128'h0;
        reuse    = 1'b0;
        rk_ready = 1'b0;
        test_reset();
        test_fips_stream();
        test_stall();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        test_reuse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

- Iterative AES-128 key-expansion unit.
- Sits directly upstream of the round-key XOR stage and supplies one 128-bit round key per round, in order round 0..10.
- Each key is computed on the fly from the previous one, and round keys are handed over on a valid/ready handshake so the datapath can stall.

## Interface
Parameters:
- NR, 10, number of rounds; round keys 0..NR are emitted, NR+1 keys in total; only 10 is supported.

Ports:
- clk  in  1  clock; one clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle request to begin a schedule; sampled only in IDLE.
- key_in  in  128  cipher key; byte 0 at [127:120], word w0 = [127:96]; sampled on an accepted start.
- reuse  in  1  replay the cached schedule instead of recomputing; sampled with start.
- rk  out  128  current round key, same byte order as key_in.
- rk_idx  out  4  round number of rk, 0..10.
- rk_valid  out  1  rk/rk_idx hold a valid key.
- rk_ready  in  1  consumer accepts rk this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after round key 10 is accepted.

## Operation
- States: IDLE, RUN. Reset state is IDLE.
- Reset values of all outputs: rk=0, rk_idx=0, rk_valid=0, busy=0, done=0.
- IDLE: start=1 loads the key register with key_in, sets rk_idx=0 and goes to RUN.
- start while in RUN is ignored.
- RUN: rk_valid=1 and busy=1.
- A handshake is a cycle with rk_valid and rk_ready both high.
- On a handshake with rk_idx<10:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[rk_idx+1],24'h0}
  - w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - rk_idx increments by 1.
- RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the AES S-box to each byte.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- On a handshake with rk_idx==10: go to IDLE, rk_valid drops, done pulses for one cycle, and rk holds the round-10 key.
- rk_ready low: rk, rk_idx and rk_valid stay stable, with no limit on stall length.
- rk_ready high while rk_valid is low has no effect.
- rst asserted mid-schedule: immediate return to IDLE with reset values. A partial schedule is discarded, not resumed.

## Timing
- The cycle after an accepted start gives rk_valid=1, rk_idx=0, rk=key_in.
- Each handshake at edge N presents the next key from edge N onward, so the next key is visible in cycle N+1.
- With rk_ready held high, 11 keys are delivered in 11 consecutive cycles.
- done is asserted in the cycle following the round-10 handshake.
- start is accepted in that same cycle if it is present, so back-to-back schedules run with no dead cycle beyond IDLE.
- The next-key path is combinational: 4 S-box lookups plus a 4-deep XOR chain, registered once per round.

## Configuration
- Macro: AES_KEY_SCHED_CACHE_EN.
- Defined:
  - An 11×128 cache is written with rk at every handshake, at address rk_idx.
  - cache_ok sets when a schedule completes.
  - cache_ok clears on rst, or on an accepted start with reuse=0.
  - start with reuse=1 and cache_ok=1 ignores key_in; rk is read from cache[rk_idx] with the same handshake and timing.
  - reuse=1 with cache_ok=0 behaves as reuse=0.
- Not defined: no cache and no cache_ok. reuse is ignored and every start recomputes from key_in.

## Structure
- Shared package aes_pkg:
  - AES_NR=10.
  - Rcon table as a localparam array.
  - 128-bit block typedef.
  - State enum {IDLE, RUN}.
- Sub-module aes_sbox, one byte in and one byte out, combinational, instantiated 4× for SubWord. It is reused later by the SubBytes stage.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> rk_idx 0..10 on consecutive cycles:
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done is a single pulse.
- Same key with rk_ready toggled randomly and a 7-cycle stall at idx 4 -> rk and rk_idx stable during stalls, identical key sequence, no skipped or duplicated index.
- start pulsed with a different key at idx 5 -> ignored; the sequence continues unchanged.
- rst asserted at idx 6 -> outputs return to 0 asynchronously. A new start gives idx0 = the new key_in one cycle later.
- Schedule of the all-zero key, then start again in the done cycle -> second schedule begins with no lost cycle; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_KEY_SCHED_CACHE_EN: complete the FIPS key, then start with reuse=1 and key_in=0 -> FIPS round keys are replayed. With the macro undefined, the same stimulus yields the all-zero-key schedule.
